uart_loader: RTL

Program-load controller that sits behind the UART receiver and in front of the CPU instruction memory. Consumes the receiver's one-cycle byte strobes, parses a framed load packet (magic, word count, little-endian 32-bit words, XOR checksum), writes each assembled word into instruction memory, and holds the CPU in reset until a load completes cleanly. Enables reloading programs over the serial link without resynthesis.

---
 rtl/uart_loader_pkg.sv | 18 +
 rtl/byte_packer.sv | 46 ++++
 rtl/uart_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  // Loader controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // First byte of every load packet.
  localparam logic [7:0] MAGIC = 8'hA5;

  // Instruction word width.
  localparam int WORD_W = 32;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a
// running XOR of every byte accepted since the last clear.
module byte_packer
  import uart_loader_pkg::*;
(
  input  logic              bot_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_last,
  output logic [7:0]        acc
);

  logic [1:0]  idx;
  logic [23:0] lanes;

  // Lane capture, byte index and checksum accumulator.
  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset) begin
      idx   <= 2'd0;
      lanes <= 24'd0;
      acc   <= 8'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      lanes <= 24'd0;
      acc   <= 8'd0;
    end else if (byte_en) begin
      acc <= acc ^ byte_in;
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The 4th byte is taken straight from the input so the complete word is
  // available in the same cycle as its last strobe.
  assign word      = {byte_in, lanes};
  assign word_last = (idx == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// Program-load controller: parses magic/count/data/checksum packets from the
// UART receiver, writes words into instruction memory and holds the CPU in
// reset until a packet has been accepted cleanly.
//
// Handshake: rx_status is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, every strobe is consumed in the cycle it appears. mem_we,
// load_done and load_err are one-cycle strobes with no acknowledge.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 4096
) (
  input  logic              bot_clk,
  input  logic              reset,
  input  logic              rx_status,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output state_t            dbg_state
);

  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state, state_nxt;
  logic [7:0]          words_left;
  logic [ADDR_W-1:0]   addr;
  logic [TO_W-1:0]     to_cnt;

  logic                do_count, do_write, do_done, do_err, hold_set;
  logic                timeout;
  logic                pk_en;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_last;
  logic [7:0]          pk_acc;

  assign pk_en = rx_status && (state == ST_DATA);

  byte_packer u_packer (
    .bot_clk   (bot_clk),
    .reset     (reset),
    .clear     (do_count),
    .byte_en   (pk_en),
    .byte_in   (rx_data),
    .word      (pk_word),
    .word_last (pk_last),
    .acc       (pk_acc)
  );

  // A byte in the same cycle always beats the timeout.
  assign timeout = (state != ST_IDLE) && !rx_status && (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nxt = state;
    do_count  = 1'b0;
    do_write  = 1'b0;
    do_done   = 1'b0;
    do_err    = 1'b0;
    hold_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_status && rx_data == MAGIC) begin
          state_nxt = ST_COUNT;
          hold_set  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (rx_status) begin
          do_count  = 1'b1;
          state_nxt = (rx_data == 8'd0) ? ST_CHECK : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_status && pk_last) begin
          do_write = 1'b1;
          if (words_left == 8'd1) state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rx_status) begin
          state_nxt = ST_IDLE;
          if (rx_data == pk_acc) do_done = 1'b1;
          else                   do_err  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      do_err    = 1'b1;
    end
  end

  // Word counter and write address; address wraps at 2^ADDR_W.
  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset) begin
      words_left <= 8'd0;
      addr       <= BASE_ADDR;
    end else if (do_count) begin
      words_left <= rx_data;
      addr       <= BASE_ADDR;
    end else if (do_write) begin
      words_left <= words_left - 8'd1;
      addr       <= addr + ADDR_ONE;
    end
  end

  // Inter-byte timeout counter, idle-cleared and cleared by every byte.
  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset)                             to_cnt <= '0;
    else if (state == ST_IDLE || rx_status) to_cnt <= '0;
    else if (to_cnt != TO_LAST)             to_cnt <= to_cnt + TO_ONE;
  end

  // Registered memory port, status strobes and CPU hold.
  always_ff @(posedge bot_clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we    <= do_write;
      load_done <= do_done;
      load_err  <= do_err;
      if (do_write) begin
        mem_addr  <= addr;
        mem_wdata <= pk_word;
      end
      if (hold_set)     cpu_hold <= 1'b1;
      else if (do_done) cpu_hold <= 1'b0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
